// File: rtl/decode_stage.sv
// RV32I decode stage: registers the fetched instruction and PC and presents decoded
// register addresses, immediate, one-hot opcode class and exception flags to execute.
module decode_stage #(
    parameter int IWIDTH   = 32,
    parameter int PC_WIDTH = 32
) (
    input  logic                ds_clk,
    input  logic                ds_rst,
    input  logic [IWIDTH-1:0]   ds_i_instr,
    input  logic [PC_WIDTH-1:0] ds_i_pc,
    input  logic                ds_i_ce,
    input  logic                ds_i_stall,
    input  logic                ds_i_flush,
    output logic                ds_o_stall,
    output logic                ds_o_flush,
    output logic                ds_o_ce,
    output logic [4:0]          ds_o_rs1_raddr,
    output logic [4:0]          ds_o_rs2_raddr,
    output logic [4:0]          ds_o_addr_rs1,
    output logic [4:0]          ds_o_addr_rs2,
    output logic [4:0]          ds_o_addr_rd,
    output logic [31:0]         ds_o_imm,
    output logic [2:0]          ds_o_funct3,
    output logic                ds_o_funct7_b5,
    output logic [10:0]         ds_o_opcode,
    output logic [PC_WIDTH-1:0] ds_o_pc,
    output logic                ds_o_illegal,
    output logic                ds_o_ecall,
    output logic                ds_o_ebreak
);

    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;

    logic [31:0] instr;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [31:0] imm_d;
    logic [10:0] opcode_d;
    logic        illegal_d, ecall_d, ebreak_d;
    logic        zero_rd, zero_rs1, zero_rs2;

    assign instr = ds_i_instr[31:0];

    assign ds_o_stall     = ds_i_stall;
    assign ds_o_flush     = ds_i_flush;
    assign ds_o_rs1_raddr = instr[19:15];
    assign ds_o_rs2_raddr = instr[24:20];

    assign imm_i = {{20{instr[31]}}, instr[31:20]};
    assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u = {instr[31:12], 12'h000};
    assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

    always_comb begin
        opcode_d  = '0;
        imm_d     = '0;
        illegal_d = 1'b0;
        ecall_d   = 1'b0;
        ebreak_d  = 1'b0;
        zero_rd   = 1'b0;
        zero_rs1  = 1'b0;
        zero_rs2  = 1'b1;
        case (instr[6:0])
            OP_RTYPE: begin
                opcode_d[0] = 1'b1;
                zero_rs2    = 1'b0;
            end
            OP_ITYPE: begin
                opcode_d[1] = 1'b1;
                imm_d       = imm_i;
            end
            OP_LOAD: begin
                opcode_d[2] = 1'b1;
                imm_d       = imm_i;
            end
            OP_STORE: begin
                opcode_d[3] = 1'b1;
                imm_d       = imm_s;
                zero_rd     = 1'b1;
                zero_rs2    = 1'b0;
            end
            OP_BRANCH: begin
                opcode_d[4] = 1'b1;
                imm_d       = imm_b;
                zero_rd     = 1'b1;
                zero_rs2    = 1'b0;
            end
            OP_JAL: begin
                opcode_d[5] = 1'b1;
                imm_d       = imm_j;
                zero_rs1    = 1'b1;
            end
            OP_JALR: begin
                opcode_d[6] = 1'b1;
                imm_d       = imm_i;
            end
            OP_LUI: begin
                opcode_d[7] = 1'b1;
                imm_d       = imm_u;
                zero_rs1    = 1'b1;
            end
            OP_AUIPC: begin
                opcode_d[8] = 1'b1;
                imm_d       = imm_u;
                zero_rs1    = 1'b1;
            end
            OP_SYSTEM: begin
                opcode_d[9] = 1'b1;
                // funct3 != 0 is a CSR access and is legal here
                if (instr == 32'h0000_0073)
                    ecall_d = 1'b1;
                else if (instr == 32'h0010_0073)
                    ebreak_d = 1'b1;
                else if (instr[14:12] == 3'b000)
                    illegal_d = 1'b1;
            end
            OP_FENCE: opcode_d[10] = 1'b1;
            default:  illegal_d = 1'b1;
        endcase
    end

    always_ff @(posedge ds_clk or negedge ds_rst) begin
        if (!ds_rst) begin
            ds_o_ce        <= 1'b0;
            ds_o_addr_rs1  <= '0;
            ds_o_addr_rs2  <= '0;
            ds_o_addr_rd   <= '0;
            ds_o_imm       <= '0;
            ds_o_funct3    <= '0;
            ds_o_funct7_b5 <= 1'b0;
            ds_o_opcode    <= '0;
            ds_o_pc        <= '0;
            ds_o_illegal   <= 1'b0;
            ds_o_ecall     <= 1'b0;
            ds_o_ebreak    <= 1'b0;
        end else if (ds_i_flush) begin
            ds_o_ce <= 1'b0;
        end else if (!ds_i_stall) begin
            ds_o_ce <= ds_i_ce;
            if (ds_i_ce) begin
                ds_o_addr_rs1  <= zero_rs1 ? 5'd0 : instr[19:15];
                ds_o_addr_rs2  <= zero_rs2 ? 5'd0 : instr[24:20];
                ds_o_addr_rd   <= zero_rd  ? 5'd0 : instr[11:7];
                ds_o_imm       <= imm_d;
                ds_o_funct3    <= instr[14:12];
                ds_o_funct7_b5 <= instr[30];
                ds_o_opcode    <= opcode_d;
                ds_o_pc        <= ds_i_pc;
                ds_o_illegal   <= illegal_d;
                ds_o_ecall     <= ecall_d;
                ds_o_ebreak    <= ebreak_d;
            end
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: decode vectors, stall/flush/bubble handshake,
// a 36-instruction stream and asynchronous reset.
module tb_decode_stage;

    logic        ds_clk = 1'b0;
    logic        ds_rst;
    logic [31:0] ds_i_instr;
    logic [31:0] ds_i_pc;
    logic        ds_i_ce, ds_i_stall, ds_i_flush;
    logic        ds_o_stall, ds_o_flush, ds_o_ce;
    logic [4:0]  ds_o_rs1_raddr, ds_o_rs2_raddr;
    logic [4:0]  ds_o_addr_rs1, ds_o_addr_rs2, ds_o_addr_rd;
    logic [31:0] ds_o_imm;
    logic [2:0]  ds_o_funct3;
    logic        ds_o_funct7_b5;
    logic [10:0] ds_o_opcode;
    logic [31:0] ds_o_pc;
    logic        ds_o_illegal, ds_o_ecall, ds_o_ebreak;

    int checks   = 0;
    int failures = 0;

    decode_stage #(.IWIDTH(32), .PC_WIDTH(32)) dut (
        .ds_clk(ds_clk), .ds_rst(ds_rst),
        .ds_i_instr(ds_i_instr), .ds_i_pc(ds_i_pc), .ds_i_ce(ds_i_ce),
        .ds_i_stall(ds_i_stall), .ds_i_flush(ds_i_flush),
        .ds_o_stall(ds_o_stall), .ds_o_flush(ds_o_flush), .ds_o_ce(ds_o_ce),
        .ds_o_rs1_raddr(ds_o_rs1_raddr), .ds_o_rs2_raddr(ds_o_rs2_raddr),
        .ds_o_addr_rs1(ds_o_addr_rs1), .ds_o_addr_rs2(ds_o_addr_rs2),
        .ds_o_addr_rd(ds_o_addr_rd), .ds_o_imm(ds_o_imm),
        .ds_o_funct3(ds_o_funct3), .ds_o_funct7_b5(ds_o_funct7_b5),
        .ds_o_opcode(ds_o_opcode), .ds_o_pc(ds_o_pc),
        .ds_o_illegal(ds_o_illegal), .ds_o_ecall(ds_o_ecall), .ds_o_ebreak(ds_o_ebreak)
    );

    always #5 ds_clk = ~ds_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge ds_clk);
        #1;
    endtask

    task automatic load(input logic [31:0] instr, input logic [31:0] pc);
        ds_i_instr = instr;
        ds_i_pc    = pc;
        ds_i_ce    = 1'b1;
        step();
    endtask

    task automatic check_fields(input string tag, input logic [10:0] opc, input logic [4:0] rd,
                                input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] imm);
        check({tag, "_opcode"}, 32'(ds_o_opcode), 32'(opc));
        check({tag, "_rd"},     32'(ds_o_addr_rd), 32'(rd));
        check({tag, "_rs1"},    32'(ds_o_addr_rs1), 32'(rs1));
        check({tag, "_rs2"},    32'(ds_o_addr_rs2), 32'(rs2));
        check({tag, "_imm"},    ds_o_imm, imm);
        check({tag, "_ce"},     32'(ds_o_ce), 32'd1);
    endtask

    task automatic check_exc(input string tag, input logic ill, input logic ec, input logic eb);
        check({tag, "_illegal"}, 32'(ds_o_illegal), 32'(ill));
        check({tag, "_ecall"},   32'(ds_o_ecall), 32'(ec));
        check({tag, "_ebreak"},  32'(ds_o_ebreak), 32'(eb));
    endtask

    initial begin
        logic [31:0] ins;
        ds_rst = 1'b1; ds_i_instr = '0; ds_i_pc = '0;
        ds_i_ce = 1'b0; ds_i_stall = 1'b0; ds_i_flush = 1'b0;
        #2 ds_rst = 1'b0;
        #2;
        check("rst_ce", 32'(ds_o_ce), 32'd0);
        check("rst_pc", ds_o_pc, 32'd0);
        check("rst_opcode", 32'(ds_o_opcode), 32'd0);
        check("rst_imm", ds_o_imm, 32'd0);
        repeat (2) step();
        ds_rst = 1'b1;

        // addi x1,x0,5
        ds_i_instr = 32'h0050_0093;
        #1 check("addi_raddr1", 32'(ds_o_rs1_raddr), 32'd0);
        check("addi_raddr2", 32'(ds_o_rs2_raddr), 32'd5);
        load(32'h0050_0093, 32'h100);
        check_fields("addi", 11'h002, 5'd1, 5'd0, 5'd0, 32'h5);
        check("addi_pc", ds_o_pc, 32'h100);
        check_exc("addi", 1'b0, 1'b0, 1'b0);

        load(32'h0020_A423, 32'h104);
        check_fields("sw", 11'h008, 5'd0, 5'd1, 5'd2, 32'h8);
        check("sw_funct3", 32'(ds_o_funct3), 32'd2);

        load(32'hFE20_8EE3, 32'h108);
        check_fields("beq", 11'h010, 5'd0, 5'd1, 5'd2, 32'hFFFF_FFFC);
        check("beq_f7b5", 32'(ds_o_funct7_b5), 32'd1);

        load(32'h1234_52B7, 32'h10C);
        check_fields("lui", 11'h080, 5'd5, 5'd0, 5'd0, 32'h1234_5000);

        // jal x1,+8
        load(32'h0080_00EF, 32'h110);
        check_fields("jal", 11'h020, 5'd1, 5'd0, 5'd0, 32'h8);

        load(32'h0000_0073, 32'h114);
        check("ecall_opcode", 32'(ds_o_opcode), 32'h200);
        check_exc("ecall", 1'b0, 1'b1, 1'b0);

        load(32'h0010_0073, 32'h118);
        check_exc("ebreak", 1'b0, 1'b0, 1'b1);

        // wfi: SYSTEM funct3=000 but not ecall/ebreak
        load(32'h1050_0073, 32'h11C);
        check("wfi_opcode", 32'(ds_o_opcode), 32'h200);
        check_exc("wfi", 1'b1, 1'b0, 1'b0);

        load(32'h0000_0000, 32'h120);
        check("zero_opcode", 32'(ds_o_opcode), 32'h0);
        check_exc("zero", 1'b1, 1'b0, 1'b0);

        // stall: outputs frozen while fetch keeps changing
        load(32'h0050_0093, 32'h200);
        ds_i_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            ds_i_instr = 32'h0010_0113 + (32'(i) << 20);
            ds_i_pc    = 32'h300 + 32'(i) * 4;
            #1 check("stall_out", 32'(ds_o_stall), 32'd1);
            step();
            check("stall_imm", ds_o_imm, 32'h5);
            check("stall_pc", ds_o_pc, 32'h200);
            check("stall_ce", 32'(ds_o_ce), 32'd1);
        end
        ds_i_flush = 1'b1;
        #1 check("flush_out", 32'(ds_o_flush), 32'd1);
        check("flush_ce_before", 32'(ds_o_ce), 32'd1);
        step();
        check("stallflush_ce", 32'(ds_o_ce), 32'd0);
        check("flush_pc_hold", ds_o_pc, 32'h200);
        ds_i_stall = 1'b0; ds_i_flush = 1'b0;

        load(32'h0050_0093, 32'h204);
        check("reload_ce", 32'(ds_o_ce), 32'd1);
        ds_i_ce = 1'b0;
        ds_i_pc = 32'h999;
        step();
        check("bubble_ce", 32'(ds_o_ce), 32'd0);
        check("bubble_pc_hold", ds_o_pc, 32'h204);

        // stream: addi x(i+1), x(i), i
        for (int i = 0; i < 36; i++) begin
            ins = {12'(i), 5'(i), 3'b000, 5'(i + 1), 7'b0010011};
            ds_i_instr = ins;
            ds_i_pc    = 32'(i) * 4;
            ds_i_ce    = 1'b1;
            #1 check("stream_raddr", 32'(ds_o_rs1_raddr), 32'(ins[19:15]));
            step();
            check("stream_pc", ds_o_pc, 32'(i) * 4);
            check("stream_imm", ds_o_imm, 32'(i));
        end

        // asynchronous reset mid-run, checked before the next edge
        check("prerst_ce", 32'(ds_o_ce), 32'd1);
        ds_rst = 1'b0;
        #1;
        check("arst_ce", 32'(ds_o_ce), 32'd0);
        check("arst_pc", ds_o_pc, 32'd0);
        check("arst_imm", ds_o_imm, 32'd0);
        check("arst_rd", 32'(ds_o_addr_rd), 32'd0);
        check("arst_opcode", 32'(ds_o_opcode), 32'd0);
        #1 ds_rst = 1'b1;
        load(32'h1234_52B7, 32'h400);
        check_fields("post_rst", 11'h080, 5'd5, 5'd0, 5'd0, 32'h1234_5000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
